// File: rtl/ad7357_decim.sv
// Block-sum decimator for paired AD7357 samples: optional offset-binary to two's complement
// conversion, per-channel accumulation of 2^DECIM_LOG2 samples, one-entry valid/ready output slot.
module ad7357_decim #(
    parameter int DECIM_LOG2 = 4,
    parameter bit SIGNED_OUT = 1'b1,
    localparam int OW = 14 + DECIM_LOG2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_in_valid,
    input  logic [13:0]   i_in_a,
    input  logic [13:0]   i_in_b,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [OW-1:0] o_out_a,
    output logic [OW-1:0] o_out_b,
    output logic [15:0]   o_drop_cnt,
    input  logic          i_drop_clr
);

    localparam int CW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam logic [CW-1:0] LAST = CW'((1 << DECIM_LOG2) - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [OW-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [OW-1:0]   sum_a, sum_b;
    logic            done, drop;

    // Flipping the MSB turns offset binary into two's complement; the signed cast then sign-extends.
    function automatic logic [OW-1:0] extend(input logic [13:0] s);
        logic signed [13:0] t;
        t = s ^ 14'h2000;
        if (SIGNED_OUT)
            return OW'(t);
        return OW'(s);
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        drop_cnt_d  = drop_cnt_q;
        done        = 1'b0;
        sum_a       = acc_a_q + extend(i_in_a);
        sum_b       = acc_b_q + extend(i_in_b);

        case (state_q)
            IDLE: begin
                acc_a_d = '0;
                acc_b_d = '0;
                count_d = '0;
                if (i_en)
                    state_d = ACCUM;
            end
            ACCUM: begin
                if (!i_en) begin
                    state_d = IDLE;
                    acc_a_d = '0;
                    acc_b_d = '0;
                    count_d = '0;
                end else if (i_in_valid) begin
                    if (count_q == LAST) begin
                        done    = 1'b1;
                        acc_a_d = '0;
                        acc_b_d = '0;
                        count_d = '0;
                    end else begin
                        acc_a_d = sum_a;
                        acc_b_d = sum_b;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A finished block only loses out when the slot is full and not being drained this cycle.
        drop = done && out_valid_q && !i_out_ready;
        if (done && !drop) begin
            out_valid_d = 1'b1;
            out_a_d     = sum_a;
            out_b_d     = sum_b;
        end else if (out_valid_q && i_out_ready) begin
            out_valid_d = 1'b0;
        end

        if (i_drop_clr)
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign o_out_valid = out_valid_q;
    assign o_out_a     = out_a_q;
    assign o_out_b     = out_b_q;
    assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ad7357_decim.sv
// Scoreboard bench for ad7357_decim: a 4-sample signed instance checked against a list-based
// reference model, plus a pass-through unsigned instance checked directly.
module tb_ad7357_decim;

    localparam int L = 2;
    localparam int N = 1 << L;

    logic        clk, rst_n, en, in_valid, out_ready, drop_clr;
    logic [13:0] in_a, in_b;
    logic        out_valid, out_valid0;
    logic [15:0] out_a, out_b, drop_cnt, drop_cnt0;
    logic [13:0] out_a0, out_b0;

    ad7357_decim #(.DECIM_LOG2(L), .SIGNED_OUT(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_in_valid(in_valid),
        .i_in_a(in_a), .i_in_b(in_b), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_a(out_a), .o_out_b(out_b), .o_drop_cnt(drop_cnt), .i_drop_clr(drop_clr)
    );

    ad7357_decim #(.DECIM_LOG2(0), .SIGNED_OUT(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_in_valid(in_valid),
        .i_in_a(in_a), .i_in_b(in_b), .o_out_valid(out_valid0), .i_out_ready(out_ready),
        .o_out_a(out_a0), .o_out_b(out_b0), .o_drop_cnt(drop_cnt0), .i_drop_clr(drop_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: collect converted samples of the open block, sum when N are in hand.
    typedef struct { int a; int b; } res_t;
    res_t exp_q[$];
    int   blk_a[$], blk_b[$];
    bit   m_en_prev, m_slot_full;
    int   m_drop;

    function automatic int conv(input logic [13:0] x);
        return int'(x) - 8192;
    endfunction

    always @(posedge clk) begin : model
        bit xfer, done, drop;
        int sa, sb;
        if (!rst_n) begin
            exp_q.delete(); blk_a.delete(); blk_b.delete();
            m_en_prev = 0; m_slot_full = 0; m_drop = 0;
        end else begin
            xfer = m_slot_full && out_ready;
            done = 0; sa = 0; sb = 0;
            if (!en) begin
                blk_a.delete(); blk_b.delete();
            end else if (m_en_prev && in_valid) begin
                blk_a.push_back(conv(in_a));
                blk_b.push_back(conv(in_b));
                if (blk_a.size() == N) begin
                    done = 1;
                    foreach (blk_a[i]) begin sa += blk_a[i]; sb += blk_b[i]; end
                    blk_a.delete(); blk_b.delete();
                end
            end
            m_en_prev = en;
            drop = done && m_slot_full && !out_ready;
            if (done && !drop) begin
                exp_q.push_back('{sa, sb});
                m_slot_full = 1;
            end else if (xfer) begin
                m_slot_full = 0;
            end
            if (drop_clr) m_drop = drop ? 1 : 0;
            else if (drop && m_drop < 65535) m_drop++;
        end
    end

    always @(negedge clk) begin : monitor
        if (rst_n) begin
            check("valid", out_valid, m_slot_full);
            check("drop_cnt", drop_cnt, m_drop);
            if (out_valid) begin
                if (exp_q.size() == 0) check("sb_depth", exp_q.size(), 1);
                else begin
                    check("out_a", $signed(out_a), exp_q[0].a);
                    check("out_b", $signed(out_b), exp_q[0].b);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic [13:0] a, input logic [13:0] b, input int n);
        repeat (n) begin
            in_valid = 1'b1; in_a = a; in_b = b;
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 0; en = 0; in_valid = 0; out_ready = 0; drop_clr = 0; in_a = 0; in_b = 0;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_a", out_a, 0);
        check("rst_drop", drop_cnt, 0);
        step();
        rst_n = 1; en = 1; out_ready = 1;
        idle(2);

        pulse(14'h2000, 14'h3FFF, N);
        check("blk_mid_a", $signed(out_a), 0);
        check("blk_mid_b", $signed(out_b), 32764);
        pulse(14'h3FFF, 14'h0000, N);
        check("blk_max_a", $signed(out_a), 32764);
        check("blk_min_b", $signed(out_b), -32768);
        pulse(14'h0000, 14'h2000, N);
        check("blk_min_a", $signed(out_a), -32768);
        idle(2);

        // Two blocks against a stalled consumer: first held, second dropped.
        out_ready = 0;
        pulse(14'h2100, 14'h1F00, N);
        idle(3);
        check("hold_valid", out_valid, 1);
        check("hold_a", $signed(out_a), 1024);
        check("hold_b", $signed(out_b), -1024);
        pulse(14'h3000, 14'h1000, N);
        check("held_a", $signed(out_a), 1024);
        check("drop_one", drop_cnt, 1);
        out_ready = 1;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_keep_a", $signed(out_a), 1024);

        // Block completes on the very cycle the full slot drains.
        out_ready = 0;
        pulse(14'h2400, 14'h2000, N);
        pulse(14'h1000, 14'h3000, N - 1);
        out_ready = 1;
        pulse(14'h1000, 14'h3000, 1);
        check("swap_valid", out_valid, 1);
        check("swap_a", $signed(out_a), -16384);
        check("swap_b", $signed(out_b), 16384);
        check("swap_nodrop", drop_cnt, 1);
        idle(1);

        // Partial block discarded by disable.
        pulse(14'h3FFF, 14'h3FFF, 2);
        en = 0;
        idle(2);
        en = 1;
        idle(2);
        pulse(14'h2001, 14'h1FFF, N);
        check("partial_a", $signed(out_a), 4);
        check("partial_b", $signed(out_b), -4);
        idle(1);

        // Pass-through instance: one-cycle latency, unsigned.
        pulse(14'h1234, 14'h0ABC, 1);
        check("pt_valid", out_valid0, 1);
        check("pt_a", out_a0, 32'h1234);
        check("pt_b", out_b0, 32'h0ABC);
        idle(1);
        check("pt_valid_off", out_valid0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 2) begin
                en = ~en; in_valid = 0;
                idle(2);
            end else begin
                in_valid  = ($urandom_range(99) < 60);
                in_a      = 14'($urandom);
                in_b      = 14'($urandom);
                out_ready = 1'($urandom_range(1));
                drop_clr  = ($urandom_range(99) < 3);
                step();
            end
        end
        drop_clr = 0; in_valid = 0; en = 1;
        idle(2);

        // Drop counter saturation on the pass-through instance: one drop per cycle.
        out_ready = 1;
        step();
        out_ready = 0; drop_clr = 1;
        step();
        drop_clr = 0;
        check("sat_start", drop_cnt0, 0);
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            in_a = 14'($urandom); in_b = 14'($urandom);
            step();
        end
        check("sat_99", drop_cnt0, 99);
        for (int i = 0; i < 65500; i++) begin
            in_a = 14'($urandom); in_b = 14'($urandom);
            step();
        end
        check("sat_ffff", drop_cnt0, 32'hFFFF);
        drop_clr = 1;
        step();
        check("clr_with_drop", drop_cnt0, 1);
        in_valid = 0;
        step();
        check("clr_alone", drop_cnt0, 0);
        drop_clr = 0;

        // Asynchronous reset with a pending result and a half-filled block.
        pulse(14'h2222, 14'h1111, N + 2);
        #1;
        rst_n = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_a", out_a, 0);
        check("arst_b", out_b, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_valid0", out_valid0, 0);
        step();
        rst_n = 1; out_ready = 1;
        idle(2);
        pulse(14'h2005, 14'h1FFD, N);
        check("post_rst_a", $signed(out_a), 20);
        check("post_rst_b", $signed(out_b), -12);
        idle(3);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
